// File: rtl/lpnest_agu.sv
// Loop-nest address sequencer: walks an NDIM-deep nest and emits one pad address per rdy/ack transfer.
// Optional stall/catch-up cycle counter output enabled by defining LPNEST_PERF_EN.
module lpnest_agu #(
  parameter int NDIM  = 4,
  parameter int IDXW  = 8,
  parameter int ADDRW = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stall,
  input  logic                  i_abort,
  input  logic [NDIM*IDXW-1:0]  i_size,
  input  logic [NDIM*ADDRW-1:0] i_stride,
  input  logic [ADDRW-1:0]      i_base,
  input  logic [ADDRW:0]        i_avail,
  output logic                  o_rdy,
  input  logic                  i_ack,
  output logic [ADDRW-1:0]      o_addr,
  output logic [NDIM*IDXW-1:0]  o_idx,
  output logic [NDIM-1:0]       o_last,
  output logic                  o_busy,
  output logic                  o_done
`ifdef LPNEST_PERF_EN
  ,
  output logic [15:0]           o_stall_cnt
`endif
);

  // Handshake: an address transfers in a cycle where o_rdy && i_ack and no abort;
  // o_rdy is never a function of i_ack.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDXW-1:0]  size_q   [NDIM];
  logic [ADDRW-1:0] stride_q [NDIM];
  logic [ADDRW-1:0] base_q;
  logic [IDXW-1:0]  idx_q    [NDIM];
  logic [ADDRW-1:0] off_q    [NDIM];

  logic [ADDRW-1:0] addr_sum;
  logic [NDIM-1:0]  last;
  logic [NDIM-1:0]  carry;
  logic             all_last;
  logic             rdy;
  logic             xfer;
  logic             start_acc;

  for (genvar g = 0; g < NDIM; g++) begin : g_dim
    assign last[g] = (idx_q[g] == (size_q[g] - IDXW'(1)));
    assign o_idx[g*IDXW +: IDXW] = idx_q[g];
  end

  // Address is base plus the running per-dimension offsets, wrapping mod 2^ADDRW.
  always_comb begin
    addr_sum = base_q;
    for (int d = 0; d < NDIM; d++) begin
      addr_sum = addr_sum + off_q[d];
    end
  end

  // A dimension steps when every inner dimension sits at its last index.
  always_comb begin
    logic c;
    c = 1'b1;
    carry = '0;
    for (int d = 0; d < NDIM; d++) begin
      carry[d] = c;
      c = c & last[d];
    end
  end

  assign all_last  = &last;
  assign rdy       = (state_q == S_RUN) && ({1'b0, addr_sum} < i_avail);
  assign xfer      = rdy && i_ack && !i_abort;
  assign start_acc = (state_q == S_IDLE) && i_start && !i_abort;

  assign o_rdy  = rdy;
  assign o_addr = addr_sum;
  assign o_last = last;
  assign o_busy = (state_q == S_RUN) || (state_q == S_STALL);
  assign o_done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (i_start) state_d = S_RUN;
        S_RUN: begin
          if (xfer && all_last) state_d = S_DONE;
          else if (i_stall)     state_d = S_STALL;
        end
        S_STALL: if (!i_stall) state_d = S_RUN;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Size 0 is stored as 1 so the wrap compare never needs a special case.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      base_q <= '0;
      for (int d = 0; d < NDIM; d++) begin
        size_q[d]   <= IDXW'(1);
        stride_q[d] <= '0;
      end
    end else if (start_acc) begin
      base_q <= i_base;
      for (int d = 0; d < NDIM; d++) begin
        size_q[d]   <= (i_size[d*IDXW +: IDXW] == '0) ? IDXW'(1) : i_size[d*IDXW +: IDXW];
        stride_q[d] <= i_stride[d*ADDRW +: ADDRW];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int d = 0; d < NDIM; d++) begin
        idx_q[d] <= '0;
        off_q[d] <= '0;
      end
    end else if (i_abort || start_acc) begin
      for (int d = 0; d < NDIM; d++) begin
        idx_q[d] <= '0;
        off_q[d] <= '0;
      end
    end else if (xfer) begin
      for (int d = 0; d < NDIM; d++) begin
        if (carry[d]) begin
          if (last[d]) begin
            idx_q[d] <= '0;
            off_q[d] <= '0;
          end else begin
            idx_q[d] <= idx_q[d] + IDXW'(1);
            off_q[d] <= off_q[d] + stride_q[d];
          end
        end
      end
    end
  end

`ifdef LPNEST_PERF_EN
  logic stall_cyc;
  assign stall_cyc = (state_q == S_STALL) || ((state_q == S_RUN) && !rdy);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
    end else if (start_acc) begin
      o_stall_cnt <= '0;
    end else if (stall_cyc && (o_stall_cnt != 16'hFFFF)) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lpnest_agu.sv
// Directed table-driven bench for lpnest_agu: nest walk, catch-up, stall, abort, wrap/size-0.
// Define LPNEST_PERF_EN to also exercise the stall counter.
module tb_lpnest_agu;

  localparam int NDIM  = 4;
  localparam int IDXW  = 8;
  localparam int ADDRW = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start, stall, abort, ack;
  logic [NDIM*IDXW-1:0]  size;
  logic [NDIM*ADDRW-1:0] stride;
  logic [ADDRW-1:0]      base;
  logic [ADDRW:0]        avail;
  logic                  rdy;
  logic [ADDRW-1:0]      addr;
  logic [NDIM*IDXW-1:0]  idx;
  logic [NDIM-1:0]       last;
  logic                  busy, done;
`ifdef LPNEST_PERF_EN
  logic [15:0]           stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic             start, stall, abort, ack;
    logic [ADDRW:0]   avail;
    logic             exp_rdy;
    logic [ADDRW-1:0] exp_addr;
    logic             exp_busy, exp_done;
    logic [NDIM-1:0]  exp_last;
  } vec_t;

  vec_t vecs[$];

  lpnest_agu #(.NDIM(NDIM), .IDXW(IDXW), .ADDRW(ADDRW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_stall  (stall),
    .i_abort  (abort),
    .i_size   (size),
    .i_stride (stride),
    .i_base   (base),
    .i_avail  (avail),
    .o_rdy    (rdy),
    .i_ack    (ack),
    .o_addr   (addr),
    .o_idx    (idx),
    .o_last   (last),
    .o_busy   (busy),
    .o_done   (done)
`ifdef LPNEST_PERF_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [NDIM*IDXW-1:0] sz, input logic [NDIM*ADDRW-1:0] st,
                         input logic [ADDRW-1:0] b);
    size   = sz;
    stride = st;
    base   = b;
  endtask

  // One record per clock: inputs driven at negedge, outputs compared 1ns later.
  task automatic add(input logic s, input logic sl, input logic ab, input logic ak,
                     input logic [ADDRW:0] av, input logic r, input logic [ADDRW-1:0] a,
                     input logic bz, input logic dn, input logic [NDIM-1:0] l);
    vec_t v;
    v.start = s;  v.stall = sl; v.abort = ab; v.ack = ak; v.avail = av;
    v.exp_rdy = r; v.exp_addr = a; v.exp_busy = bz; v.exp_done = dn; v.exp_last = l;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    vec_t v;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      start = v.start; stall = v.stall; abort = v.abort; ack = v.ack; avail = v.avail;
      #1;
      check($sformatf("%s[%0d].rdy", tag, i), 32'(rdy), 32'(v.exp_rdy));
      check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(v.exp_busy));
      check($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(v.exp_done));
      if (v.exp_rdy) begin
        check($sformatf("%s[%0d].addr", tag, i), 32'(addr), 32'(v.exp_addr));
        check($sformatf("%s[%0d].last", tag, i), 32'(last), 32'(v.exp_last));
      end
    end
    vecs.delete();
    @(negedge clk);
    start = 1'b0; stall = 1'b0; abort = 1'b0; ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; stall = 1'b0; abort = 1'b0; ack = 1'b0;
    avail = 11'd1023;
    set_cfg('0, '0, '0);
    repeat (2) @(negedge clk);
    #1;
    check("reset.rdy", 32'(rdy), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.addr", 32'(addr), 32'd0);
    check("reset.idx", idx, 32'd0);
    check("reset.last", 32'(last), 32'hF);
`ifdef LPNEST_PERF_EN
    check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Nest walk sizes {3,2,1,1}, strides {1,4,0,0}, base 8; a mid-walk start is ignored.
    set_cfg({8'd1, 8'd1, 8'd2, 8'd3}, {10'd0, 10'd0, 10'd4, 10'd1}, 10'd8);
    add(1,0,0,0, 1023, 0,  0, 0,0, 4'b0000);
    add(0,0,0,1, 1023, 1,  8, 1,0, 4'b1100);
    add(0,0,0,1, 1023, 1,  9, 1,0, 4'b1100);
    add(1,0,0,1, 1023, 1, 10, 1,0, 4'b1101);
    add(0,0,0,1, 1023, 1, 12, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 13, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 14, 1,0, 4'b1111);
    add(0,0,0,0, 1023, 0,  0, 0,1, 4'b0000);
    add(0,0,0,0, 1023, 0,  0, 0,0, 4'b0000);
    run_vecs("nest");

    // Address wrap with size 0 on the outer dimensions.
    set_cfg({8'd0, 8'd0, 8'd0, 8'd8}, {10'd0, 10'd0, 10'd0, 10'd1}, 10'd1020);
    add(1,0,0,0, 1024, 0,    0, 0,0, 4'b0000);
    add(0,0,0,1, 1024, 1, 1020, 1,0, 4'b1110);
    add(0,0,0,1, 1024, 1, 1021, 1,0, 4'b1110);
    add(0,0,0,1, 1024, 1, 1022, 1,0, 4'b1110);
    add(0,0,0,1, 1024, 1, 1023, 1,0, 4'b1110);
    add(0,0,0,1, 1024, 1,    0, 1,0, 4'b1110);
    add(0,0,0,1, 1024, 1,    1, 1,0, 4'b1110);
    add(0,0,0,1, 1024, 1,    2, 1,0, 4'b1110);
    add(0,0,0,1, 1024, 1,    3, 1,0, 4'b1111);
    add(0,0,0,0, 1024, 0,    0, 0,1, 4'b0000);
    run_vecs("wrap");

    // Catch-up: avail 2 blocks address 2 until avail rises in the same cycle.
    set_cfg({8'd1, 8'd1, 8'd1, 8'd6}, {10'd0, 10'd0, 10'd0, 10'd1}, 10'd0);
    add(1,0,0,0,    2, 0, 0, 0,0, 4'b0000);
    add(0,0,0,1,    2, 1, 0, 1,0, 4'b1110);
    add(0,0,0,1,    2, 1, 1, 1,0, 4'b1110);
    add(0,0,0,1,    2, 0, 0, 1,0, 4'b0000);
    add(0,0,0,1,    3, 1, 2, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 3, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 4, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 5, 1,0, 4'b1111);
    add(0,0,0,0, 1023, 0, 0, 0,1, 4'b0000);
    run_vecs("catchup");

    // Stall raised during the 3rd transfer; issue resumes at the 4th address.
    add(1,0,0,0, 1023, 0, 0, 0,0, 4'b0000);
    add(0,0,0,1, 1023, 1, 0, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 1, 1,0, 4'b1110);
    add(0,1,0,1, 1023, 1, 2, 1,0, 4'b1110);
    add(0,1,0,1, 1023, 0, 0, 1,0, 4'b0000);
    add(0,0,0,1, 1023, 0, 0, 1,0, 4'b0000);
    add(0,0,0,1, 1023, 1, 3, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 4, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 5, 1,0, 4'b1111);
    add(0,0,0,0, 1023, 0, 0, 0,1, 4'b0000);
    run_vecs("stall");

    // Abort with simultaneous ack at idx 4, abort beats start in IDLE, restart from base.
    set_cfg({8'd1, 8'd1, 8'd1, 8'd6}, {10'd0, 10'd0, 10'd0, 10'd1}, 10'd16);
    add(1,0,0,0, 1023, 0,  0, 0,0, 4'b0000);
    add(0,0,0,1, 1023, 1, 16, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 17, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 18, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 19, 1,0, 4'b1110);
    add(0,0,1,1, 1023, 1, 20, 1,0, 4'b1110);
    add(0,0,0,0, 1023, 0,  0, 0,0, 4'b0000);
    add(0,0,0,0, 1023, 0,  0, 0,0, 4'b0000);
    add(1,0,1,0, 1023, 0,  0, 0,0, 4'b0000);
    add(0,0,0,1, 1023, 0,  0, 0,0, 4'b0000);
    add(1,0,0,0, 1023, 0,  0, 0,0, 4'b0000);
    add(0,0,0,1, 1023, 1, 16, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 17, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 18, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 19, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 20, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 21, 1,0, 4'b1111);
    add(0,0,0,0, 1023, 0,  0, 0,1, 4'b0000);
    run_vecs("abort");

`ifdef LPNEST_PERF_EN
    // Three catch-up cycles plus two stall cycles give a count of 5.
    set_cfg({8'd1, 8'd1, 8'd1, 8'd6}, {10'd0, 10'd0, 10'd0, 10'd1}, 10'd0);
    add(1,0,0,0,    2, 0, 0, 0,0, 4'b0000);
    add(0,0,0,1,    2, 1, 0, 1,0, 4'b1110);
    add(0,0,0,1,    2, 1, 1, 1,0, 4'b1110);
    add(0,0,0,1,    2, 0, 0, 1,0, 4'b0000);
    add(0,0,0,1,    2, 0, 0, 1,0, 4'b0000);
    add(0,0,0,1,    2, 0, 0, 1,0, 4'b0000);
    add(0,1,0,1, 1023, 1, 2, 1,0, 4'b1110);
    add(0,1,0,1, 1023, 0, 0, 1,0, 4'b0000);
    add(0,0,0,1, 1023, 0, 0, 1,0, 4'b0000);
    add(0,0,0,1, 1023, 1, 3, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 4, 1,0, 4'b1110);
    add(0,0,0,1, 1023, 1, 5, 1,0, 4'b1111);
    add(0,0,0,0, 1023, 0, 0, 0,1, 4'b0000);
    run_vecs("perf");
    check("perf.cnt_after_done", 32'(stall_cnt), 32'd5);
    @(negedge clk);
    start = 1'b1;
    #1;
    check("perf.cnt_at_start", 32'(stall_cnt), 32'd5);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("perf.cnt_cleared", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
